// File: rtl/buma_serial_addsub_if.sv
// Operand/result bundle for the digit-serial add/subtract unit.
// master = issuing controller, slave = arithmetic unit.
interface buma_serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] O;
  logic             overflow;
  logic             carry;

  modport master (
    output start, sub, I1, I2,
    input  busy, done, O, overflow, carry
  );

  modport slave (
    input  start, sub, I1, I2,
    output busy, done, O, overflow, carry
  );
endinterface

// File: rtl/buma_serial_addsub.sv
// Digit-serial two's-complement add/subtract, DIGIT bits per clock,
// LSB first, with signed overflow and carry-out on completion.
module buma_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                reset_n,
  buma_serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_n;
  logic             c;
  logic [DIGIT:0]   sum;
  logic             last;
  logic             accept;
  logic             cm;

  assign sum = {1'b0, a[DIGIT-1:0]}
             + {1'b0, b[DIGIT-1:0]}
             + (DIGIT+1)'(c);
  assign last   = (cnt == CW'(N - 1));
  assign accept = bus.start &&
                  (state == IDLE || state == DONE);
  // carry into the slice MSB recovered from its sum bit
  assign cm = a[DIGIT-1] ^ b[DIGIT-1] ^ sum[DIGIT-1];

  generate
    if (WIDTH > DIGIT) begin : g_shift
      assign r_n = {sum[DIGIT-1:0], r[WIDTH-1:DIGIT]};
    end else begin : g_single
      assign r_n = sum[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = bus.start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a            <= '0;
      b            <= '0;
      r            <= '0;
      c            <= 1'b0;
      cnt          <= '0;
      bus.O        <= '0;
      bus.overflow <= 1'b0;
      bus.carry    <= 1'b0;
    end else if (accept) begin
      a   <= bus.I1;
      b   <= bus.sub ? ~bus.I2 : bus.I2;
      c   <= bus.sub;
      cnt <= '0;
    end else if (state == RUN) begin
      a   <= a >> DIGIT;
      b   <= b >> DIGIT;
      c   <= sum[DIGIT];
      r   <= r_n;
      cnt <= cnt + CW'(1);
      if (last) begin
        bus.O        <= r_n;
        bus.carry    <= sum[DIGIT];
        bus.overflow <= cm ^ sum[DIGIT];
      end
    end
  end
endmodule
